// File: rtl/imem_loader.sv
// Loads a little-endian byte stream into instruction memory as 32-bit words,
// optionally NOP-filling first, and holds the core in reset until the image is complete.
module imem_loader #(
  parameter int          IMEM_WORDS = 512,
  parameter int          ADDR_W     = 9,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013,
  parameter bit          FILL_NOP   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RECV, S_FLUSH, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_W:0]   FULL      = (ADDR_W+1)'(IMEM_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_WORDS - 1);

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic        fin;
  logic        hs, ovf, word_end, aligned_last;
  logic [31:0] packed_word;
  logic        ready_next, busy_next, done_next, err_next, cpu_rst_next;

  // A byte transfers on any rising edge where s_valid and s_ready are both high;
  // s_ready is registered and never depends on s_valid in the same cycle.
  assign hs           = s_valid & s_ready;
  assign ovf          = (words_loaded == FULL);
  assign word_end     = (byte_cnt == 2'd3) | s_last;
  assign aligned_last = s_last & (byte_cnt == 2'd3);
  assign packed_word  = {8'h00, shift} | ({24'h00_0000, s_data} << {byte_cnt, 3'b000});

  // State register plus registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cpu_rst <= 1'b1;
    end else begin
      state   <= state_next;
      s_ready <= ready_next;
      busy    <= busy_next;
      done    <= done_next;
      err     <= err_next;
      cpu_rst <= cpu_rst_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_next = FILL_NOP ? S_CLEAR : S_RECV;
      end
      S_CLEAR: begin
        if (imem_waddr == LAST_ADDR) state_next = S_RECV;
      end
      S_RECV: begin
        // fin marks the cycle carrying the final aligned write; DONE follows it.
        if (fin)                               state_next = S_DONE;
        else if (hs && ovf)                    state_next = S_ERR;
        else if (hs && s_last && !aligned_last) state_next = S_FLUSH;
      end
      S_FLUSH: state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_next   = (state_next == S_RECV) &&
                   !((state == S_RECV) && hs && !ovf && aligned_last);
    busy_next    = (state_next == S_CLEAR) || (state_next == S_RECV) ||
                   (state_next == S_FLUSH);
    done_next    = (state_next == S_DONE);
    err_next     = (state_next == S_ERR);
    cpu_rst_next = (state_next != S_DONE);
  end

  // Write port and packing datapath; words_loaded doubles as the stream write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      byte_cnt     <= '0;
      shift        <= '0;
      fin          <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            words_loaded <= '0;
            byte_cnt     <= '0;
            shift        <= '0;
            fin          <= 1'b0;
            imem_waddr   <= '0;
            if (FILL_NOP) begin
              imem_we    <= 1'b1;
              imem_wdata <= NOP_WORD;
            end
          end
        end
        S_CLEAR: begin
          if (imem_waddr != LAST_ADDR) begin
            imem_we    <= 1'b1;
            imem_waddr <= imem_waddr + ADDR_W'(1);
          end
        end
        S_RECV: begin
          if (hs && !ovf) begin
            if (word_end) begin
              imem_we      <= 1'b1;
              imem_waddr   <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= packed_word;
              words_loaded <= words_loaded + (ADDR_W+1)'(1);
              byte_cnt     <= '0;
              shift        <= '0;
              fin          <= aligned_last;
            end else begin
              shift    <= packed_word[23:0];
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 512-word NOP-filling instance and a 4-word no-fill instance.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_last, use_b;
  logic [7:0]  s_data;

  logic        a_ready, a_we, a_cpu_rst, a_busy, a_done, a_err;
  logic [8:0]  a_waddr;
  logic [31:0] a_wdata;
  logic [9:0]  a_wl;
  logic        b_ready, b_we, b_cpu_rst, b_busy, b_done, b_err;
  logic [1:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [2:0]  b_wl;

  logic        a_start, a_valid, b_start, b_valid, cur_ready;
  logic [31:0] mem_a [512];
  logic [31:0] mem_b [4];
  int          wr_a = 0, wr_b = 0, bad_a = 0, bad_b = 0;
  int          checks = 0, errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [7:0]  img3 [12] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                             8'h01, 8'h02, 8'h03, 8'h04};
  logic [31:0] w3 [3]    = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0403_0201};
  logic [31:0] w5 [4]    = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D};

  assign a_start   = start & ~use_b;
  assign a_valid   = s_valid & ~use_b;
  assign b_start   = start & use_b;
  assign b_valid   = s_valid & use_b;
  assign cur_ready = use_b ? b_ready : a_ready;

  imem_loader #(.IMEM_WORDS(512), .ADDR_W(9), .NOP_WORD(NOP), .FILL_NOP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .s_valid(a_valid), .s_ready(a_ready),
    .s_data(s_data), .s_last(s_last), .imem_we(a_we), .imem_waddr(a_waddr),
    .imem_wdata(a_wdata), .cpu_rst(a_cpu_rst), .busy(a_busy), .done(a_done),
    .err(a_err), .words_loaded(a_wl)
  );

  imem_loader #(.IMEM_WORDS(4), .ADDR_W(2), .NOP_WORD(NOP), .FILL_NOP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .s_valid(b_valid), .s_ready(b_ready),
    .s_data(s_data), .s_last(s_last), .imem_we(b_we), .imem_waddr(b_waddr),
    .imem_wdata(b_wdata), .cpu_rst(b_cpu_rst), .busy(b_busy), .done(b_done),
    .err(b_err), .words_loaded(b_wl)
  );

  always #5 clk = ~clk;

  // Memory models capture every write; writes while not busy are flagged.
  always @(posedge clk) begin
    if (a_we === 1'b1) begin
      mem_a[a_waddr] = a_wdata;
      wr_a++;
      if (a_busy !== 1'b1) bad_a++;
    end
    if (b_we === 1'b1) begin
      mem_b[b_waddr] = b_wdata;
      wr_b++;
      if (b_busy !== 1'b1) bad_b++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    t = 0;
    while (cur_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("handshake_wait", 32'(t < 1000), 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic preset_mem_a();
    for (int i = 0; i < 512; i++) mem_a[i] = 32'hDEAD_BEEF;
    wr_a = 0;
  endtask

  task automatic check_nop_tail(input string tag, input int from);
    int bad;
    bad = 0;
    for (int i = from; i < 512; i++) if (mem_a[i] !== NOP) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; use_b = 1'b0;
    preset_mem_a();

    // Reset state and idle behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_cpu_rst", a_cpu_rst, 1);
    check("rst_done", a_done, 0);
    check("rst_we", a_we, 0);
    check("rst_ready", a_ready, 0);
    check("rst_wl", a_wl, 0);
    repeat (3) @(negedge clk);
    check("idle_ready", a_ready, 0);
    check("idle_busy", a_busy, 0);

    // NOP fill followed by a two-word image
    do_start();
    check("clr_we", a_we, 1);
    check("clr_addr0", a_waddr, 0);
    check("clr_data", a_wdata, NOP);
    check("clr_busy", a_busy, 1);
    check("clr_cpu_rst", a_cpu_rst, 1);
    send_byte(8'h13, 1'b0, 0);
    check("clr_count", wr_a, 512);
    send_byte(8'h05, 1'b0, 0);
    send_byte(8'h40, 1'b0, 0);
    send_byte(8'h06, 1'b0, 0);
    check("w0_we", a_we, 1);
    check("w0_addr", a_waddr, 0);
    check("w0_data", a_wdata, 32'h0640_0513);
    send_byte(8'h93, 1'b0, 0);
    send_byte(8'h05, 1'b0, 0);
    send_byte(8'h90, 1'b0, 0);
    send_byte(8'h01, 1'b1, 0);
    check("w1_we", a_we, 1);
    check("w1_addr", a_waddr, 1);
    check("w1_data", a_wdata, 32'h0190_0593);
    check("w1_ready_low", a_ready, 0);
    check("w1_not_done", a_done, 0);
    @(negedge clk);
    check("t2_done", a_done, 1);
    check("t2_cpu_rst", a_cpu_rst, 0);
    check("t2_busy", a_busy, 0);
    check("t2_we", a_we, 0);
    check("t2_wl", a_wl, 2);
    check("t2_mem0", mem_a[0], 32'h0640_0513);
    check("t2_mem1", mem_a[1], 32'h0190_0593);
    check("t2_writes", wr_a, 514);
    check_nop_tail("t2_nop_tail", 2);

    // Bytes offered in DONE are ignored
    s_valid = 1'b1; s_data = 8'h55;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    check("done_ignore_wr", wr_a, 514);
    check("done_ignore_ready", a_ready, 0);
    check("done_ignore_done", a_done, 1);

    // Gapped stream: each write one cycle after the 4th byte
    preset_mem_a();
    do_start();
    check("t3_cpu_rst_rise", a_cpu_rst, 1);
    for (int i = 0; i < 12; i++) begin
      send_byte(img3[i], (i == 11), $urandom_range(0, 3));
      if (i % 4 == 3) begin
        check("t3_we", a_we, 1);
        check("t3_addr", a_waddr, i / 4);
        check("t3_data", a_wdata, w3[i/4]);
      end
    end
    @(negedge clk);
    check("t3_done", a_done, 1);
    check("t3_wl", a_wl, 3);
    check("t3_mem0", mem_a[0], 32'h1234_5678);
    check("t3_mem1", mem_a[1], 32'hDEAD_BEEF);
    check("t3_mem2", mem_a[2], 32'h0403_0201);
    check("t3_writes", wr_a, 515);
    check_nop_tail("t3_nop_tail", 3);

    // Misaligned image: partial word flushed, then ERR
    do_start();
    send_byte(8'hAA, 1'b0, 0);
    send_byte(8'hBB, 1'b0, 0);
    send_byte(8'hCC, 1'b0, 0);
    send_byte(8'hDD, 1'b0, 0);
    send_byte(8'hEE, 1'b0, 0);
    send_byte(8'hFF, 1'b1, 0);
    check("fl_we", a_we, 1);
    check("fl_addr", a_waddr, 1);
    check("fl_data", a_wdata, 32'h0000_FFEE);
    check("fl_busy", a_busy, 1);
    @(negedge clk);
    check("t4_err", a_err, 1);
    check("t4_cpu_rst", a_cpu_rst, 1);
    check("t4_busy", a_busy, 0);
    check("t4_we", a_we, 0);
    check("t4_wl", a_wl, 2);
    check("t4_mem0", mem_a[0], 32'hDDCC_BBAA);
    check("t4_mem1", mem_a[1], 32'h0000_FFEE);

    // Recovery; start during CLEAR does not disturb the fill sweep
    do_start();
    repeat (4) @(negedge clk);
    check("busy_addr4", a_waddr, 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_ignored", a_waddr, 5);
    check("busy_start_err", a_err, 0);
    send_byte(8'h13, 1'b0, 0);
    send_byte(8'h05, 1'b0, 0);
    send_byte(8'h40, 1'b0, 0);
    send_byte(8'h06, 1'b1, 0);
    @(negedge clk);
    check("t4r_done", a_done, 1);
    check("t4r_err", a_err, 0);
    check("t4r_wl", a_wl, 1);
    check("t4r_mem0", mem_a[0], 32'h0640_0513);
    check("t4r_mem1", mem_a[1], NOP);

    // Overflow on the 4-word instance
    use_b = 1'b1;
    do_start();
    check("t5_ready", b_ready, 1);
    check("t5_busy", b_busy, 1);
    check("t5_we", b_we, 0);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i + 1), 1'b0, 0);
      if (i % 4 == 3) begin
        check("t5_wwe", b_we, 1);
        check("t5_waddr", b_waddr, i / 4);
        check("t5_wdata", b_wdata, w5[i/4]);
      end
    end
    check("t5_wl4", b_wl, 4);
    send_byte(8'h11, 1'b1, 0);
    check("t5_err", b_err, 1);
    check("t5_we_after", b_we, 0);
    check("t5_ready_after", b_ready, 0);
    check("t5_wl", b_wl, 4);
    @(negedge clk);
    check("t5_writes", wr_b, 4);
    for (int i = 0; i < 4; i++) check("t5_mem", mem_b[i], w5[i]);

    // Reset mid-RECV aborts without a write
    use_b = 1'b0;
    preset_mem_a();
    do_start();
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    check("t6_pre_writes", wr_a, 512);
    rst = 1'b1;
    #1;
    check("t6_busy", a_busy, 0);
    check("t6_ready", a_ready, 0);
    check("t6_we", a_we, 0);
    check("t6_cpu_rst", a_cpu_rst, 1);
    check("t6_wl", a_wl, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t6_no_write", wr_a, 512);
    do_start();
    for (int i = 0; i < 8; i++) send_byte(img3[i], (i == 7), 0);
    @(negedge clk);
    check("t6_done", a_done, 1);
    check("t6_wl2", a_wl, 2);
    check("t6_mem0", mem_a[0], 32'h1234_5678);
    check("t6_mem1", mem_a[1], 32'hDEAD_BEEF);
    check("t6_mem2", mem_a[2], NOP);

    check("we_outside_busy_a", bad_a, 0);
    check("we_outside_busy_b", bad_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
